ballot_session_ctrl: RTL and testbench
======================================

// Module: ballot_session_ctrl
// PURPOSE
//  Booth-session controller between the per-button debouncers and the vote tally registers.
//  - Officer arms the booth; exactly one vote is then accepted per session.
//  - Simultaneous presses are rejected; an idle voter times out.
//  - In results mode, the block cycles a display through the per-candidate tallies.
//  - Sole source of tally increment strobes; the tally block counts only when vote_inc is asserted.
// PARAMETERS
//  N_CAND       4     number of candidates / buttons
//  CNT_W        8     tally and served-counter width
//  TIMEOUT_CYC  1000  ARMED cycles allowed before the session is abandoned
//  ACK_CYC      20    cycles vote_ack is held after an accepted vote
//  DWELL_CYC    50    cycles each tally stays on display in RESULTS
// PORTS
//  clk          in   1             system clock, rising edge
//  reset        in   1             asynchronous, active-low reset
//  mode         in   1             0 = voting, 1 = results
//  arm          in   1             officer enable, 1-cycle pulse
//  valid_vote   in   N_CAND        debounced 1-cycle vote pulses, bit i = candidate i
//  tally        in   N_CAND*CNT_W  packed tallies, candidate i in bits [i*CNT_W +: CNT_W]
//  vote_inc     out  N_CAND        one-hot tally increment strobe, 1 cycle
//  booth_ready  out  1             high while in ARMED
//  vote_ack     out  1             confirmation indicator
//  reject       out  1             1-cycle pulse on a multi-button press
//  timeout      out  1             1-cycle pulse on session expiry
//  disp_sel     out  $clog2(N_CAND)  index of the tally on display
//  disp_value   out  CNT_W         displayed tally; 0 outside RESULTS
//  served       out  CNT_W         accepted votes since reset; saturates at all-ones
// BEHAVIOUR
//  Reset
//  - While reset=0: state = IDLE; all outputs 0; timer = 0.
//  - Reset asserted mid-session discards the session; no vote_inc is emitted.
//  States
//  - IDLE -> ARMED on arm=1 with mode=0. Timer loads TIMEOUT_CYC-1.
//  - ARMED, popcount(valid_vote)==1: next cycle vote_inc = valid_vote, served += 1, vote_ack = 1;
//    go to ACK with timer = ACK_CYC-1. Latency from vote to strobe is exactly 1 cycle.
//  - ARMED, popcount(valid_vote)>1: reject pulses next cycle; no vote_inc; stay in ARMED;
//    the timer is not reloaded.
//  - ARMED, no vote and timer==0: timeout pulses next cycle; go to IDLE.
//    A vote in the same cycle as expiry wins; no timeout pulse is emitted.
//  - ARMED, arm=1 again: ignored; the timer is not reloaded.
//  - ACK: vote_ack held high for ACK_CYC cycles total, then IDLE. valid_vote and arm are ignored.
//  - Any state, mode=1: go to RESULTS next cycle; an armed session is aborted with no pulse.
//    A vote arriving in the same cycle as mode=1 is dropped.
//  - RESULTS: on entry disp_sel = 0 and timer = DWELL_CYC-1.
//    When the timer reaches 0, disp_sel advances and wraps N_CAND-1 -> 0, and the timer reloads.
//    disp_value is registered from tally[disp_sel], 1-cycle lag.
//  - RESULTS -> IDLE on mode=0; disp_sel and disp_value clear to 0.
//  Output rules
//  - vote_inc is never multi-hot and never asserted outside the ARMED->ACK transition.
//  - booth_ready = (state == ARMED).
//  - served saturates: it is not incremented at all-ones, while vote_inc still fires.
//  Timer
//  - Width $clog2(max(TIMEOUT_CYC, ACK_CYC, DWELL_CYC)).
//  - Down-counter; holds at 0 until reloaded.
// STRUCTURE
//  - Shared package ballot_pkg: state enum {IDLE, ARMED, ACK, RESULTS}; default parameter
//    constants; popcount function.
//  - Sub-module session_timer: loadable down-counter with load, load_val, zero outputs.
//    Instantiated once, shared across ARMED, ACK and RESULTS.
//  - Remainder: one state register, registered outputs, tally mux.
// TESTING
//  1 arm; valid_vote=4'b0100 three cycles later -> vote_inc=4'b0100 for 1 cycle;
//    vote_ack high 20 cycles; served=1; then IDLE, booth_ready=0.
//  2 arm; valid_vote=4'b0011 -> reject 1 cycle, vote_inc=0;
//    then valid_vote=4'b1000 -> vote_inc=4'b1000.
//  3 arm, no vote -> timeout pulse 1000 cycles after arm; booth_ready=0;
//    valid_vote=4'b0001 afterwards -> no vote_inc.
//  4 vote in ACK or IDLE (unarmed) -> no vote_inc, served unchanged.
//    Repeated arm in ARMED -> timeout still at the original deadline.
//  5 tally={8'd9,8'd7,8'd5,8'd3}, mode=1 -> disp_value 3,5,7,9,3 at 50-cycle steps;
//    mode=0 -> disp_value=0.
//  6 reset=0 pulse while ARMED -> all outputs 0, state IDLE.
//    With served forced to 8'hFF: next accepted vote -> served stays 8'hFF, vote_inc still fires.

Source files
------------

// File: rtl/ballot_pkg.sv
// ballot_pkg: shared state encoding, default parameters and helpers for the booth controller
package ballot_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, ACK, RESULTS} state_t;
    localparam int N_CAND_DEF      = 4;
    localparam int CNT_W_DEF       = 8;
    localparam int TIMEOUT_CYC_DEF = 1000;
    localparam int ACK_CYC_DEF     = 20;
    localparam int DWELL_CYC_DEF   = 50;
    function automatic int unsigned popcount(input logic [31:0] v);
        popcount = 0;
        for (int i = 0; i < 32; i++) popcount += 32'(v[i]);
    endfunction
    function automatic int max3(input int a, input int b, input int c);
        max3 = (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/session_timer.sv
// session_timer: loadable down-counter that holds at zero
//   clk, reset (async active-low), load/load_val reload the count, zero flags an expired count
module session_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    assign zero = (cnt == '0);
endmodule

// File: rtl/ballot_session_ctrl.sv
// ballot_session_ctrl: booth session FSM, sole source of tally increments, results display sequencer
//   inputs : clk, reset (async active-low), mode (0 vote / 1 results), arm, valid_vote, tally
//   outputs: vote_inc, booth_ready, vote_ack, reject, timeout, disp_sel, disp_value, served
module ballot_session_ctrl
    import ballot_pkg::*;
#(
    parameter int N_CAND      = N_CAND_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int ACK_CYC     = ACK_CYC_DEF,
    parameter int DWELL_CYC   = DWELL_CYC_DEF,
    localparam int SW         = $clog2(N_CAND),
    localparam int TW         = $clog2(max3(TIMEOUT_CYC, ACK_CYC, DWELL_CYC))
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic                    arm,
    input  logic [N_CAND-1:0]       valid_vote,
    input  logic [N_CAND*CNT_W-1:0] tally,
    output logic [N_CAND-1:0]       vote_inc,
    output logic                    booth_ready,
    output logic                    vote_ack,
    output logic                    reject,
    output logic                    timeout,
    output logic [SW-1:0]           disp_sel,
    output logic [CNT_W-1:0]        disp_value,
    output logic [CNT_W-1:0]        served
);
    state_t      state;
    logic        zero, load, go_res, arm_go, accept, dwell;
    logic [TW-1:0] load_val;
    int unsigned popc;
    assign popc     = popcount(32'(valid_vote));
    // mode=1 overrides every other event, including a vote in the same cycle
    assign go_res   = mode && state != RESULTS;
    assign arm_go   = !mode && state == IDLE && arm;
    assign accept   = !mode && state == ARMED && popc == 1;
    assign dwell    = mode && state == RESULTS && zero;
    assign load     = go_res || arm_go || accept || dwell;
    assign load_val = (go_res || dwell) ? TW'(DWELL_CYC - 1) : arm_go ? TW'(TIMEOUT_CYC - 1) : TW'(ACK_CYC - 1);
    session_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .zero     (zero)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            vote_inc    <= '0;
            booth_ready <= 1'b0;
            vote_ack    <= 1'b0;
            reject      <= 1'b0;
            timeout     <= 1'b0;
            disp_sel    <= '0;
            disp_value  <= '0;
            served      <= '0;
        end else begin
            vote_inc   <= '0;
            reject     <= 1'b0;
            timeout    <= 1'b0;
            disp_value <= (state == RESULTS && mode) ? tally[int'(disp_sel)*CNT_W +: CNT_W] : '0;
            if (mode) begin
                if (state != RESULTS) begin
                    state       <= RESULTS;
                    disp_sel    <= '0;
                    booth_ready <= 1'b0;
                    vote_ack    <= 1'b0;
                end else if (zero)
                    disp_sel <= (disp_sel == SW'(N_CAND - 1)) ? '0 : disp_sel + 1'b1;
            end else begin
                case (state)
                    IDLE: if (arm) begin
                        state       <= ARMED;
                        booth_ready <= 1'b1;
                    end
                    // a valid vote beats an expiring timer in the same cycle
                    ARMED: if (popc == 1) begin
                        state       <= ACK;
                        booth_ready <= 1'b0;
                        vote_inc    <= valid_vote;
                        vote_ack    <= 1'b1;
                        served      <= (&served) ? served : served + 1'b1;
                    end else if (popc > 1) reject <= 1'b1;
                    else if (zero) begin
                        state       <= IDLE;
                        booth_ready <= 1'b0;
                        timeout     <= 1'b1;
                    end
                    ACK: if (zero) begin
                        state    <= IDLE;
                        vote_ack <= 1'b0;
                    end
                    RESULTS: begin
                        state    <= IDLE;
                        disp_sel <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ballot_session_ctrl.sv
// tb_ballot_session_ctrl: directed and randomized checks against a deadline-based session model
module tb_ballot_session_ctrl;
    localparam int NC = 4, CW = 8, TO = 1000, AC = 20, DW = 50;
    logic          clk = 1'b0, reset = 1'b0, mode = 1'b0, arm = 1'b0;
    logic [NC-1:0] valid_vote = '0;
    logic [NC*CW-1:0] tally = '0;
    logic [NC-1:0] vote_inc;
    logic          booth_ready, vote_ack, reject, timeout;
    logic [1:0]    disp_sel;
    logic [CW-1:0] disp_value, served;
    int n_chk = 0, n_err = 0;
    int t = 0;
    bit armed, in_ack, in_res;
    int deadline, ack_until, res_start, served_m;
    logic [NC-1:0] exp_inc;
    logic          exp_rej, exp_to;
    logic [CW-1:0] exp_dval;
    int exp5[5] = '{3, 5, 7, 9, 3};

    ballot_session_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .arm         (arm),
        .valid_vote  (valid_vote),
        .tally       (tally),
        .vote_inc    (vote_inc),
        .booth_ready (booth_ready),
        .vote_ack    (vote_ack),
        .reject      (reject),
        .timeout     (timeout),
        .disp_sel    (disp_sel),
        .disp_value  (disp_value),
        .served      (served)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, t);
        end
    endtask

    task automatic model_zero();
        armed = 0; in_ack = 0; in_res = 0; served_m = 0;
        exp_inc = '0; exp_rej = 0; exp_to = 0; exp_dval = '0;
    endtask

    // sessions tracked as deadlines in cycle numbers rather than a state register
    task automatic model_edge();
        int pc;
        pc = $countones(valid_vote);
        exp_inc = '0; exp_rej = 0; exp_to = 0; exp_dval = '0;
        if (!reset) model_zero();
        else if (in_res) begin
            if (mode) exp_dval = tally[(((t - 1 - res_start) / DW) % NC) * CW +: CW];
            else in_res = 0;
        end else if (mode) begin
            in_res = 1; res_start = t; armed = 0; in_ack = 0;
        end else if (armed) begin
            if (pc == 1) begin
                exp_inc = valid_vote;
                served_m = (served_m >= 255) ? 255 : served_m + 1;
                armed = 0; in_ack = 1; ack_until = t + AC;
            end else if (pc > 1) exp_rej = 1;
            else if (t >= deadline) begin
                exp_to = 1; armed = 0;
            end
        end else if (in_ack) begin
            if (t >= ack_until) in_ack = 0;
        end else if (arm) begin
            armed = 1; deadline = t + TO;
        end
    endtask

    task automatic check_all();
        chk("vote_inc", 32'(vote_inc), 32'(exp_inc));
        chk("booth_ready", 32'(booth_ready), 32'(armed));
        chk("vote_ack", 32'(vote_ack), 32'(in_ack));
        chk("reject", 32'(reject), 32'(exp_rej));
        chk("timeout", 32'(timeout), 32'(exp_to));
        chk("disp_sel", 32'(disp_sel), in_res ? ((t - res_start) / DW) % NC : 0);
        chk("disp_value", 32'(disp_value), 32'(exp_dval));
        chk("served", 32'(served), served_m);
    endtask

    task automatic step();
        @(posedge clk);
        t++;
        model_edge();
        #1 check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        model_zero();
        #1 check_all();
        steps(3);
        reset = 1'b1;
        steps(2);
        // 1: single accepted vote, ack window, return to idle
        arm = 1; step(); arm = 0;
        steps(2);
        valid_vote = 4'b0100; step(); valid_vote = '0;
        chk("t1_inc", 32'(vote_inc), 32'h4);
        chk("t1_served", 32'(served), 1);
        steps(19);
        chk("t1_ack_held", 32'(vote_ack), 1);
        step();
        chk("t1_ack_end", 32'(vote_ack), 0);
        chk("t1_ready", 32'(booth_ready), 0);
        // 2: multi-press rejected, then a single press accepted
        arm = 1; step(); arm = 0;
        valid_vote = 4'b0011; step();
        chk("t2_reject", 32'(reject), 1);
        chk("t2_no_inc", 32'(vote_inc), 0);
        valid_vote = 4'b1000; step(); valid_vote = '0;
        chk("t2_inc", 32'(vote_inc), 32'h8);
        steps(21);
        // 3: idle voter times out exactly 1000 cycles after arm
        arm = 1; step(); arm = 0;
        steps(TO - 1);
        chk("t3_pre_to", 32'(timeout), 0);
        step();
        chk("t3_timeout", 32'(timeout), 1);
        chk("t3_ready", 32'(booth_ready), 0);
        valid_vote = 4'b0001; step(); valid_vote = '0;
        chk("t3_no_inc", 32'(vote_inc), 0);
        step();
        // 4: votes in ACK and IDLE ignored; re-arm does not extend deadline
        arm = 1; step(); arm = 0;
        valid_vote = 4'b0010; step();
        chk("t4_inc", 32'(vote_inc), 32'h2);
        step();
        chk("t4_ack_vote", 32'(vote_inc), 0);
        valid_vote = '0; steps(20);
        valid_vote = 4'b0001; step(); valid_vote = '0;
        chk("t4_idle_vote", 32'(vote_inc), 0);
        chk("t4_served", 32'(served), 3);
        arm = 1; step(); arm = 0;
        for (int k = 1; k < TO; k++) begin
            arm = (k == 500); step();
        end
        arm = 0; step();
        chk("t4_deadline", 32'(timeout), 1);
        // 5: results display walks the tallies at dwell steps
        tally = {8'd9, 8'd7, 8'd5, 8'd3};
        mode = 1; step();
        for (int k = 0; k < 5; k++) begin
            steps(k == 0 ? 1 : DW);
            chk("t5_disp", 32'(disp_value), exp5[k]);
        end
        mode = 0; step();
        chk("t5_clear", 32'(disp_value), 0);
        chk("t5_sel", 32'(disp_sel), 0);
        // 6: asynchronous reset while armed
        arm = 1; step(); arm = 0;
        steps(5);
        reset = 0;
        #1 model_zero();
        check_all();
        chk("t6_ready", 32'(booth_ready), 0);
        steps(2);
        reset = 1;
        steps(2);
        // randomized traffic
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 299) == 0) mode = ~mode;
            arm = ($urandom_range(0, 19) == 0);
            valid_vote = ($urandom_range(0, 24) == 0) ? 4'($urandom) : '0;
            if ($urandom_range(0, 9) == 0) tally = $urandom;
            reset = ($urandom_range(0, 1999) != 0);
            step();
        end
        reset = 1; mode = 0; arm = 0; valid_vote = '0;
        steps(30);
        // drive served into saturation; increments must keep firing
        for (int i = 0; i < 300; i++) begin
            arm = 1; step(); arm = 0;
            valid_vote = 4'(1 << $urandom_range(0, 3)); step();
            if (i == 299) chk("sat_inc", 32'(vote_inc), 32'(valid_vote));
            valid_vote = '0;
            steps(21);
        end
        chk("sat_served", 32'(served), 255);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
